data_mem_responder: RTL

Responder end of the CPU data-memory port: accepts load/store requests (address, write data, funct3 size) from the RV32I datapath, performs byte-lane selection and sign/zero extension, and serves them from an internal word-organised RAM after a programmable number of wait states. It sits between the datapath's `dAddr`/`dWdata`/`dRdata` signals and the memory array. It is the multi-cycle replacement for a combinational data RAM.

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I data-memory definitions: load/store size codes and the
// responder state encoding.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dm_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the datapath (master) and the
// memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte enables and replicated
// write data on the store side, lane extraction and extension on the load side.
module mem_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    logic        misaligned;
    logic        illegal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_o       = '0;
        wword_o    = wdata_i;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                illegal = we_i && (funct3_i == F3_BU);
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                illegal    = we_i && (funct3_i == F3_HU);
            end
            F3_W: begin
                misaligned = |addr_lo_i;
                be_o       = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        err_o = misaligned | illegal;
        if (err_o) begin
            be_o = '0;
        end
    end

    always_comb begin
        byte_sel = rdata_raw_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            F3_W:    rdata_o = rdata_raw_i;
            default: rdata_o = '0;
        endcase
        if (err_o) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// commits against a word RAM and emits a one-cycle registered response.
module data_mem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_responder_if.slave bus
);

    localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              hs;
    logic              commit;

    logic [ADDR_W+1:0] cur_addr;
    logic              cur_we;
    logic [2:0]        cur_funct3;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       raw_word;

    logic [3:0]        be;
    logic [31:0]       wword;
    logic              align_err;
    logic [31:0]       rdata_ext;

    logic [31:0]       ram [2**ADDR_W];

    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    // With zero wait states the commit happens on the handshake edge itself,
    // so the live request is used instead of the captured copy.
    always_comb begin
        if (state_q == DM_IDLE) begin
            cur_addr   = bus.req_addr[ADDR_W+1:0];
            cur_we     = bus.req_we;
            cur_funct3 = bus.req_funct3;
            cur_wdata  = bus.req_wdata;
        end else begin
            cur_addr   = addr_q;
            cur_we     = we_q;
            cur_funct3 = funct3_q;
            cur_wdata  = wdata_q;
        end
    end

    assign idx      = cur_addr[ADDR_W+1:2];
    assign raw_word = ram[idx];

    mem_lane_align u_align (
        .funct3_i    (cur_funct3),
        .we_i        (cur_we),
        .addr_lo_i   (cur_addr[1:0]),
        .wdata_i     (cur_wdata),
        .rdata_raw_i (raw_word),
        .be_o        (be),
        .wword_o     (wword),
        .err_o       (align_err),
        .rdata_o     (rdata_ext)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        hs            = 1'b0;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        unique case (state_q)
            DM_IDLE: begin
                bus.req_ready = rst;
                if (bus.req_valid && rst) begin
                    hs = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = DM_WAIT;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = DM_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DM_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_RESP: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
        if (commit) begin
            rdata_d = (cur_we || align_err) ? 32'd0 : rdata_ext;
            err_d   = align_err;
        end
    end

    assign bus.rsp_valid = (state_q == DM_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DM_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (hs) begin
                addr_q   <= bus.req_addr[ADDR_W+1:0];
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                wdata_q  <= bus.req_wdata;
            end
        end
    end

    // RAM is not reset; a store pending when reset arrives is dropped.
    always_ff @(posedge clk) begin
        if (commit && rst && cur_we && !align_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule
